// File: rtl/commit_store_queue_if.sv
// D$ write-port bundle between the commit store queue (master) and the
// data cache (slave). Carries the req/gnt handshake and the store fields.
interface commit_store_queue_if #(
  parameter int unsigned ADDR_WIDTH = 56,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] be;
  logic [1:0]              size;

  modport master (output req, addr, data, be, size, input gnt);
  modport slave  (input req, addr, data, be, size, output gnt);
endinterface

// File: rtl/commit_store_queue.sv
// commit_store_queue: two-level store queue behind the commit stage.
// Speculative stores wait for commit_i, then move to the committed queue,
// which drains in order to the D$ write port through a req/gnt handshake.
// Optional feature macro: COMMIT_SQ_FWD_CHECK_EN enables the page-offset
// alias check (page_offset_matches_o); undefined, the output is tied to 0.
module commit_store_queue #(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH   = 56,
  parameter int unsigned DATA_WIDTH   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [ADDR_WIDTH-1:0]   st_paddr_i,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic [DATA_WIDTH/8-1:0] st_be_i,
  input  logic [1:0]              st_size_i,
  input  logic                    commit_i,
  output logic                    commit_ready_o,
  output logic                    no_st_pending_o,
  commit_store_queue_if.master    dcache,
  input  logic [11:0]             page_offset_i,
  output logic                    page_offset_matches_o
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SPW      = $clog2(SPEC_DEPTH);
  localparam int unsigned CMW      = $clog2(COMMIT_DEPTH);
  localparam logic [SPW:0] SPEC_FULL = (SPW+1)'(SPEC_DEPTH);
  localparam logic [CMW:0] CMT_FULL  = (CMW+1)'(COMMIT_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} drain_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
    logic [1:0]            size;
  } store_t;

  store_t         r_spec_mem [SPEC_DEPTH];
  logic [SPW-1:0] r_spec_rptr, r_spec_wptr;
  logic [SPW:0]   r_spec_cnt;
  store_t         r_cmt_mem [COMMIT_DEPTH];
  logic [CMW-1:0] r_cmt_rptr, r_cmt_wptr;
  logic [CMW:0]   r_cmt_cnt;
  store_t         r_last;
  drain_state_e   r_state, w_state_next;

  logic         w_enq, w_commit, w_pop;
  logic [SPW:0] w_spec_cnt_next;
  logic [CMW:0] w_cmt_cnt_next;
  store_t       w_st_in, w_head, w_out;

  assign st_ready_o      = (r_spec_cnt != SPEC_FULL);
  assign commit_ready_o  = (r_cmt_cnt != CMT_FULL);
  assign no_st_pending_o = (r_cmt_cnt == '0);

  // A store arriving with a flush is dropped; illegal commits are ignored.
  assign w_enq    = st_valid_i && st_ready_o && !flush_i;
  assign w_commit = commit_i && (r_spec_cnt != '0) && commit_ready_o;
  assign w_pop    = (r_state == S_REQ) && dcache.gnt;

  assign w_st_in = '{paddr: st_paddr_i, data: st_data_i, be: st_be_i, size: st_size_i};
  assign w_head  = r_cmt_mem[r_cmt_rptr];
  // While requesting, present the committed head; otherwise hold the last sent store.
  assign w_out   = (r_state == S_REQ) ? w_head : r_last;

  assign dcache.req  = (r_state == S_REQ);
  assign dcache.addr = w_out.paddr;
  assign dcache.data = w_out.data;
  assign dcache.be   = w_out.be;
  assign dcache.size = w_out.size;

  // Next occupancy of both queues (flush only clears the speculative side)
  always_comb begin
    w_spec_cnt_next = r_spec_cnt;
    w_cmt_cnt_next  = r_cmt_cnt;
    if (flush_i)
      w_spec_cnt_next = '0;
    else if (w_enq && !w_commit)
      w_spec_cnt_next = r_spec_cnt + 1'b1;
    else if (!w_enq && w_commit)
      w_spec_cnt_next = r_spec_cnt - 1'b1;
    if (w_commit && !w_pop)
      w_cmt_cnt_next = r_cmt_cnt + 1'b1;
    else if (!w_commit && w_pop)
      w_cmt_cnt_next = r_cmt_cnt - 1'b1;
  end

  // Drain FSM next state: look at the next count so a commit requests on the following cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmt_cnt_next != '0) w_state_next = S_REQ;
      S_REQ:   if (w_cmt_cnt_next == '0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pointers, counts, FSM state and held D$ fields
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_spec_rptr <= '0;
      r_spec_wptr <= '0;
      r_spec_cnt  <= '0;
      r_cmt_rptr  <= '0;
      r_cmt_wptr  <= '0;
      r_cmt_cnt   <= '0;
      r_last      <= '0;
      r_state     <= S_IDLE;
    end else begin
      if (w_enq)
        r_spec_wptr <= r_spec_wptr + 1'b1;
      if (w_commit) begin
        r_spec_rptr <= r_spec_rptr + 1'b1;
        r_cmt_wptr  <= r_cmt_wptr + 1'b1;
      end
      // Flush collapses the queue onto the (possibly just advanced) read pointer.
      if (flush_i)
        r_spec_wptr <= w_commit ? r_spec_rptr + 1'b1 : r_spec_rptr;
      if (w_pop) begin
        r_cmt_rptr <= r_cmt_rptr + 1'b1;
        r_last     <= w_head;
      end
      r_spec_cnt <= w_spec_cnt_next;
      r_cmt_cnt  <= w_cmt_cnt_next;
      r_state    <= w_state_next;
    end
  end

  // Entry storage; validity lives in the pointers and counts, so no reset
  always_ff @(posedge clk_i) begin
    if (w_enq)
      r_spec_mem[r_spec_wptr] <= w_st_in;
    if (w_commit)
      r_cmt_mem[r_cmt_wptr] <= r_spec_mem[r_spec_rptr];
  end

  // Flag commits with nothing to commit or no committed slot
  always_ff @(posedge clk_i) begin
    if (rst_ni)
      a_commit_legal: assert (!(commit_i && !w_commit));
  end

`ifdef COMMIT_SQ_FWD_CHECK_EN
  logic [SPEC_DEPTH-1:0]   w_spec_hit;
  logic [COMMIT_DEPTH-1:0] w_cmt_hit;
  logic                    w_unused_po;

  assign w_unused_po = ^page_offset_i[2:0];

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < SPEC_DEPTH; gi++) begin : g_spec_cmp
    logic [SPW-1:0] w_age;
    assign w_age = SPW'(gi) - r_spec_rptr;
    assign w_spec_hit[gi] = ({1'b0, w_age} < r_spec_cnt) &&
                            (r_spec_mem[gi].paddr[11:3] == page_offset_i[11:3]);
  end

  for (genvar gi = 0; gi < COMMIT_DEPTH; gi++) begin : g_cmt_cmp
    logic [CMW-1:0] w_age;
    assign w_age = CMW'(gi) - r_cmt_rptr;
    assign w_cmt_hit[gi] = ({1'b0, w_age} < r_cmt_cnt) &&
                           (r_cmt_mem[gi].paddr[11:3] == page_offset_i[11:3]);
  end

  assign page_offset_matches_o = (|w_spec_hit) || (|w_cmt_hit) ||
                                 (st_valid_i && (st_paddr_i[11:3] == page_offset_i[11:3]));
`else
  logic w_unused_po;
  assign w_unused_po           = ^page_offset_i;
  assign page_offset_matches_o = 1'b0;
`endif

endmodule

// File: tb/tb_commit_store_queue.sv
// Self-checking bench for commit_store_queue: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_commit_store_queue;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int BW = DW / 8;
`ifdef COMMIT_SQ_FWD_CHECK_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] paddr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [1:0]    size;
  } st_t;

  logic          clk_i = 1'b0;
  logic          rst_ni, flush_i, st_valid_i, commit_i;
  logic          st_ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o;
  logic [AW-1:0] st_paddr_i;
  logic [DW-1:0] st_data_i;
  logic [BW-1:0] st_be_i;
  logic [1:0]    st_size_i;
  logic [11:0]   page_offset_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain FIFOs of stores plus the last store handed to D$.
  st_t m_spec[$];
  st_t m_cmt[$];
  st_t m_last;

  commit_store_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dc_if ();

  commit_store_queue #(
    .SPEC_DEPTH(4), .COMMIT_DEPTH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .st_valid_i            (st_valid_i),
    .st_ready_o            (st_ready_o),
    .st_paddr_i            (st_paddr_i),
    .st_data_i             (st_data_i),
    .st_be_i               (st_be_i),
    .st_size_i             (st_size_i),
    .commit_i              (commit_i),
    .commit_ready_o        (commit_ready_o),
    .no_st_pending_o       (no_st_pending_o),
    .dcache                (dc_if.master),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_match();
    logic m;
    m = 1'b0;
    if (FWD_EN) begin
      foreach (m_spec[i]) if (m_spec[i].paddr[11:3] == page_offset_i[11:3]) m = 1'b1;
      foreach (m_cmt[i])  if (m_cmt[i].paddr[11:3] == page_offset_i[11:3]) m = 1'b1;
      if (st_valid_i && st_paddr_i[11:3] == page_offset_i[11:3]) m = 1'b1;
    end
    return m;
  endfunction

  task automatic check_all(input string tag);
    st_t e;
    e = (m_cmt.size() != 0) ? m_cmt[0] : m_last;
    chk({tag, ".st_ready"},     128'(st_ready_o),            128'(m_spec.size() != 4));
    chk({tag, ".commit_ready"}, 128'(commit_ready_o),        128'(m_cmt.size() != 4));
    chk({tag, ".no_pending"},   128'(no_st_pending_o),       128'(m_cmt.size() == 0));
    chk({tag, ".req"},          128'(dc_if.req),             128'(m_cmt.size() != 0));
    chk({tag, ".addr"},         128'(dc_if.addr),            128'(e.paddr));
    chk({tag, ".data"},         128'(dc_if.data),            128'(e.data));
    chk({tag, ".be"},           128'(dc_if.be),              128'(e.be));
    chk({tag, ".size"},         128'(dc_if.size),            128'(e.size));
    chk({tag, ".match"},        128'(page_offset_matches_o), 128'(exp_match()));
  endtask

  task automatic model_update();
    bit rdy, crdy;
    if (!rst_ni) begin
      m_spec.delete();
      m_cmt.delete();
      m_last = '0;
      return;
    end
    rdy  = (m_spec.size() != 4);
    crdy = (m_cmt.size() != 4);
    if (m_cmt.size() != 0 && dc_if.gnt) m_last = m_cmt.pop_front();
    if (commit_i && m_spec.size() != 0 && crdy) m_cmt.push_back(m_spec.pop_front());
    if (flush_i) m_spec.delete();
    else if (st_valid_i && rdy) m_spec.push_back('{st_paddr_i, st_data_i, st_be_i, st_size_i});
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+3.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic set_store(input logic [AW-1:0] a);
    st_paddr_i = a;
    st_data_i  = {$urandom, $urandom};
    st_be_i    = BW'($urandom);
    st_size_i  = 2'($urandom);
  endtask

  task automatic idle_inputs();
    flush_i = 0; st_valid_i = 0; commit_i = 0; dc_if.gnt = 0;
  endtask

  logic [AW-1:0] a_tmp;
  st_t           first_st;

  initial begin
    rst_ni = 0; idle_inputs(); set_store('0); page_offset_i = '0;
    repeat (2) begin @(posedge clk_i); model_update(); end
    #1; rst_ni = 1;

    // Reset state
    chk("rst.st_ready", 128'(st_ready_o), 128'(1));
    chk("rst.commit_ready", 128'(commit_ready_o), 128'(1));
    chk("rst.no_pending", 128'(no_st_pending_o), 128'(1));
    chk("rst.req", 128'(dc_if.req), 128'(0));
    chk("rst.addr", 128'(dc_if.addr), 128'(0));
    chk("rst.match", 128'(page_offset_matches_o), 128'(0));

    // Four stores without commit fill the speculative queue
    st_valid_i = 1;
    for (int i = 0; i < 4; i++) begin set_store(AW'(32'h100 + 8*i)); step("fill"); end
    st_valid_i = 0;
    chk("fill.st_ready", 128'(st_ready_o), 128'(0));
    repeat (3) step("fill_idle");
    chk("fill.req", 128'(dc_if.req), 128'(0));
    flush_i = 1; step("fill_flush"); flush_i = 0;

    // A/B back-to-back drain with grant held
    dc_if.gnt = 1; st_valid_i = 1;
    set_store(AW'(32'h1000)); step("ab_a");
    set_store(AW'(32'h2008)); step("ab_b");
    st_valid_i = 0; commit_i = 1; step("ab_c1");
    chk("ab.req_a", 128'(dc_if.req), 128'(1));
    chk("ab.addr_a", 128'(dc_if.addr), 128'(32'h1000));
    step("ab_c2"); commit_i = 0;
    chk("ab.req_b", 128'(dc_if.req), 128'(1));
    chk("ab.addr_b", 128'(dc_if.addr), 128'(32'h2008));
    step("ab_pop");
    chk("ab.no_pending", 128'(no_st_pending_o), 128'(1));
    chk("ab.req_off", 128'(dc_if.req), 128'(0));

    // Committed queue full, grant withheld: fields stay stable
    dc_if.gnt = 0; st_valid_i = 1;
    set_store(AW'(32'h3000)); first_st = '{st_paddr_i, st_data_i, st_be_i, st_size_i};
    step("full_s0");
    for (int i = 1; i < 4; i++) begin set_store(AW'(32'h3000 + 64*i)); step("full_s"); end
    st_valid_i = 0; commit_i = 1;
    repeat (4) step("full_c");
    commit_i = 0;
    for (int i = 0; i < 10; i++) begin
      chk("full.commit_ready", 128'(commit_ready_o), 128'(0));
      chk("full.addr_stable", 128'(dc_if.addr), 128'(first_st.paddr));
      chk("full.data_stable", 128'(dc_if.data), 128'(first_st.data));
      step("full_hold");
    end
    dc_if.gnt = 1; repeat (4) step("full_drain"); dc_if.gnt = 0;

    // Flush and commit together: only the head survives
    st_valid_i = 1;
    for (int i = 0; i < 3; i++) begin set_store(AW'(32'h4000 + 8*i)); step("fc_s"); end
    st_valid_i = 0; flush_i = 1; commit_i = 1; step("fc_fc");
    flush_i = 0; commit_i = 0;
    chk("fc.st_ready", 128'(st_ready_o), 128'(1));
    chk("fc.req", 128'(dc_if.req), 128'(1));
    chk("fc.addr", 128'(dc_if.addr), 128'(32'h4000));
    dc_if.gnt = 1; step("fc_pop"); dc_if.gnt = 0;
    chk("fc.no_pending", 128'(no_st_pending_o), 128'(1));
    step("fc_idle");

    // Page-offset alias check
    st_valid_i = 1; set_store(AW'(32'h80000ab8)); page_offset_i = 12'hab8; step("fwd_s");
    st_valid_i = 0;
    chk("fwd.hit", 128'(page_offset_matches_o), 128'(FWD_EN));
    page_offset_i = 12'hac0;
    chk("fwd.miss", 128'(page_offset_matches_o), 128'(0));
    page_offset_i = 12'hab8; flush_i = 1; step("fwd_flush"); flush_i = 0;
    chk("fwd.flushed", 128'(page_offset_matches_o), 128'(0));

    // Reset while requesting with three committed entries
    st_valid_i = 1;
    for (int i = 0; i < 3; i++) begin set_store(AW'(32'h5000 + 8*i)); step("rr_s"); end
    st_valid_i = 0; commit_i = 1; repeat (3) step("rr_c"); commit_i = 0;
    chk("rr.req_before", 128'(dc_if.req), 128'(1));
    rst_ni = 0; step("rr_rst"); rst_ni = 1;
    chk("rr.req_after", 128'(dc_if.req), 128'(0));
    chk("rr.no_pending", 128'(no_st_pending_o), 128'(1));
    repeat (3) step("rr_idle");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      a_tmp = AW'({$urandom, $urandom});
      a_tmp[11:3] = 9'($urandom_range(0, 7));
      set_store(a_tmp);
      st_valid_i    = ($urandom_range(0, 9) < 6);
      commit_i      = (m_spec.size() != 0) && (m_cmt.size() != 4) && ($urandom_range(0, 1) == 1);
      flush_i       = ($urandom_range(0, 11) == 0);
      dc_if.gnt     = ($urandom_range(0, 1) == 1);
      page_offset_i = {9'($urandom_range(0, 7)), 3'($urandom)};
      rst_ni        = ($urandom_range(0, 149) != 0);
      step("rand");
    end
    rst_ni = 1; idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
